// File: rtl/anim_pkg.sv
// Shared constants, state encoding and helpers for the per-frame animation sequencer.
package anim_pkg;

    localparam int H_TOTAL       = 800;
    localparam int V_DISPLAY     = 480;
    localparam int WRAP          = 400;
    localparam int BAR_WIDTH     = 40;
    localparam int LUT_LEN       = 10;
    localparam int PLAYER_X      = 200;
    localparam int SPEED_DEFAULT = 4;

    localparam int POS_W = 10;
    localparam int IDX_W = 4;
    localparam int SPD_W = 4;

    typedef enum logic [2:0] {
        ST_INIT = 3'd0,
        ST_WAIT = 3'd1,
        ST_ADV  = 3'd2,
        ST_DIV  = 3'd3,
        ST_DONE = 3'd4
    } anim_state_e;

    // A zero speed setting would freeze the scroll, so it is treated as the slowest step.
    function automatic logic [SPD_W-1:0] speed_sanitize(input logic [SPD_W-1:0] s);
        return (s == '0) ? SPD_W'(1) : s;
    endfunction

endpackage

// File: rtl/bar_index_divider.sv
// Iterative subtract-by-BAR_WIDTH divider whose quotient counter wraps modulo LUT_LEN.
module bar_index_divider
    import anim_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [POS_W-1:0] dividend,
    output logic             done,
    output logic [IDX_W-1:0] quotient
);

    localparam logic [POS_W-1:0] BW    = POS_W'(BAR_WIDTH);
    localparam logic [IDX_W-1:0] Q_MAX = IDX_W'(LUT_LEN - 1);

    logic [POS_W-1:0] rem;
    logic             active;

    // Handshake: start is a single-cycle request accepted in any cycle (it restarts the
    // division); done is a single-cycle pulse while active, and quotient is valid during
    // that pulse and stays stable until the next start.
    assign done = active && (rem < BW);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem      <= '0;
            quotient <= '0;
            active   <= 1'b0;
        end else if (start) begin
            rem      <= dividend;
            quotient <= '0;
            active   <= 1'b1;
        end else if (active) begin
            if (rem >= BW) begin
                rem      <= rem - BW;
                quotient <= (quotient == Q_MAX) ? '0 : quotient + IDX_W'(1);
            end else begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/anim_frame_sequencer.sv
// Frame-rate scroll scheduler: syncs switches, advances x_offset once per frame during
// vertical blanking and derives the player's sine-LUT index.
module anim_frame_sequencer
    import anim_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [9:0]       pix_x,
    input  logic [9:0]       pix_y,
    input  logic [3:0]       speed_sw,
    input  logic             pause_sw,
    output logic [9:0]       x_offset,
    output logic [3:0]       addr_player,
    output logic             show_player,
    output logic             frame_tick,
    output logic             busy,
    output anim_state_e      state
);

    localparam logic [9:0]       FE_X        = 10'(H_TOTAL - 1);
    localparam logic [9:0]       FE_Y        = 10'(V_DISPLAY - 1);
    localparam logic [9:0]       WRAP_V      = 10'(WRAP);
    localparam logic [9:0]       PLAYER_X_V  = 10'(PLAYER_X);
    localparam logic [IDX_W-1:0] ADDR_RESET  = IDX_W'((PLAYER_X / BAR_WIDTH) % LUT_LEN);
    localparam logic [SPD_W-1:0] SPEED_RESET = SPD_W'(SPEED_DEFAULT);

    anim_state_e      next_state;
    logic [3:0]       speed_s1, speed_s2, speed_q;
    logic             pause_s1, pause_s2, paused_q;
    logic             fe;
    logic             div_start, div_done;
    logic [IDX_W-1:0] div_q;
    logic [9:0]       sum, next_offset, dividend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            speed_s1 <= '0;
            speed_s2 <= '0;
            pause_s1 <= 1'b0;
            pause_s2 <= 1'b0;
        end else begin
            speed_s1 <= speed_sw;
            speed_s2 <= speed_s1;
            pause_s1 <= pause_sw;
            pause_s2 <= pause_s1;
        end
    end

    // Last pixel of the last visible line: everything after this is blanking.
    assign fe = (pix_x == FE_X) && (pix_y == FE_Y);

    // speed_q <= 15 and x_offset < WRAP, so one conditional subtract suffices.
    assign sum         = x_offset + {6'd0, speed_q};
    assign next_offset = (sum >= WRAP_V) ? sum - WRAP_V : sum;
    assign dividend    = PLAYER_X_V + next_offset;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_INIT;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        div_start  = 1'b0;
        case (state)
            ST_INIT: if (fe) next_state = ST_WAIT;
            ST_WAIT: if (fe) next_state = pause_s2 ? ST_DONE : ST_ADV;
            ST_ADV: begin
                div_start  = 1'b1;
                next_state = ST_DIV;
            end
            ST_DIV:  if (div_done) next_state = ST_DONE;
            ST_DONE: next_state = ST_WAIT;
            default: next_state = ST_INIT;
        endcase
    end

    assign busy       = (state == ST_ADV) || (state == ST_DIV) || (state == ST_DONE);
    assign frame_tick = (state == ST_DONE);

    bar_index_divider u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (dividend),
        .done     (div_done),
        .quotient (div_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_offset    <= '0;
            addr_player <= ADDR_RESET;
            show_player <= 1'b0;
            speed_q     <= SPEED_RESET;
            paused_q    <= 1'b0;
        end else begin
            if (fe)                         speed_q     <= speed_sanitize(speed_s2);
            if (fe && state == ST_INIT)     show_player <= 1'b1;
            if (fe && state == ST_WAIT)     paused_q    <= pause_s2;
            if (state == ST_ADV)            x_offset    <= next_offset;
            // A paused frame skips the divider, so its quotient would be stale.
            if (state == ST_DONE && !paused_q) addr_player <= div_q;
        end
    end

endmodule

// File: tb/tb_anim_frame_sequencer.sv
// Directed bench for anim_frame_sequencer; the frame event is driven directly on pix_x/pix_y.
module tb_anim_frame_sequencer;
    import anim_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [3:0]  speed_sw;
    logic        pause_sw;
    logic [9:0]  x_offset;
    logic [3:0]  addr_player;
    logic        show_player;
    logic        frame_tick;
    logic        busy;
    anim_state_e state;

    int checks = 0;
    int errors = 0;

    // Per-frame observations gathered by do_frame.
    int          g_ticks;
    int          g_busy;
    int          g_tick_at;
    logic [31:0] g_x_t1;
    logic [31:0] g_x_t2;

    int          ref_ofs;
    int          spd;
    logic [31:0] hold_x;
    logic [31:0] hold_a;
    int          pause_ticks;

    anim_frame_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .speed_sw    (speed_sw),
        .pause_sw    (pause_sw),
        .x_offset    (x_offset),
        .addr_player (addr_player),
        .show_player (show_player),
        .frame_tick  (frame_tick),
        .busy        (busy),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_addr(input int ofs);
        return ((PLAYER_X + ofs) / BAR_WIDTH) % LUT_LEN;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // One frame event, then a bounded window of blanking cycles observed at negedges.
    task automatic do_frame();
        pix_x = 10'd799;
        pix_y = 10'd479;
        @(negedge clk);
        pix_x = 10'd0;
        pix_y = 10'd480;
        g_ticks   = 0;
        g_busy    = 0;
        g_tick_at = -1;
        for (int i = 0; i < 40; i++) begin
            if (i == 0) g_x_t1 = 32'(x_offset);
            if (i == 1) g_x_t2 = 32'(x_offset);
            if (busy) g_busy++;
            if (frame_tick) begin
                g_ticks++;
                if (g_tick_at < 0) g_tick_at = i;
            end
            @(negedge clk);
        end
        pix_y = 10'd100;
    endtask

    task automatic run_frames(input int n);
        for (int i = 0; i < n; i++) do_frame();
    endtask

    initial begin
        rst_n    = 1'b0;
        pix_x    = 10'd0;
        pix_y    = 10'd100;
        speed_sw = 4'd0;
        pause_sw = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_x_offset", 32'(x_offset), 0);
        check("rst_addr", 32'(addr_player), 5);
        check("rst_show", 32'(show_player), 0);
        check("rst_tick", 32'(frame_tick), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_state", 32'(state), 32'(ST_INIT));
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Speed 0 behaves as 1; the first frame only reveals the player.
        do_frame();
        check("t1_show", 32'(show_player), 1);
        check("t1_x0", 32'(x_offset), 0);
        check("t1_a0", 32'(addr_player), 5);
        check("t1_noticks", 32'(g_ticks), 0);
        do_frame();
        check("t1_x1", 32'(x_offset), 1);
        check("t1_a1", 32'(addr_player), 5);
        check("t1_lat_t1", g_x_t1, 0);
        check("t1_lat_t2", g_x_t2, 1);
        check("t1_tick_at", 32'(g_tick_at), 7);
        check("t1_ticks", 32'(g_ticks), 1);

        // Full speed: 26 advances reach 390 with the longest divide (590 / 40).
        speed_sw = 4'd15;
        do_reset();
        do_frame();
        run_frames(26);
        check("t2_x390", 32'(x_offset), 390);
        check("t2_a390", 32'(addr_player), 4);
        check("t2_busy_max", 32'(g_busy), 17);
        check("t2_tick_at", 32'(g_tick_at), 16);
        do_frame();
        check("t2_wrap_x", 32'(x_offset), 5);
        check("t2_wrap_a", 32'(addr_player), 5);

        // Pause at 120: outputs hold while frame_tick keeps pulsing.
        do_reset();
        do_frame();
        run_frames(8);
        check("t3_x120", 32'(x_offset), 120);
        check("t3_a120", 32'(addr_player), 8);
        pause_sw = 1'b1;
        repeat (3) @(negedge clk);
        pause_ticks = 0;
        for (int f = 0; f < 3; f++) begin
            do_frame();
            pause_ticks += g_ticks;
            check("t3_hold_x", 32'(x_offset), 120);
            check("t3_hold_a", 32'(addr_player), 8);
        end
        check("t3_ticks", 32'(pause_ticks), 3);
        pause_sw = 1'b0;
        repeat (3) @(negedge clk);

        // Speed change mid-frame is picked up by that frame's update.
        speed_sw = 4'd4;
        do_reset();
        do_frame();
        run_frames(10);
        check("t4_x40", 32'(x_offset), 40);
        pix_y = 10'd100;
        speed_sw = 4'd8;
        repeat (3) @(negedge clk);
        do_frame();
        check("t4_x48", 32'(x_offset), 48);
        check("t4_a48", 32'(addr_player), 6);
        do_frame();
        check("t4_x56", 32'(x_offset), 56);
        check("t4_a56", 32'(addr_player), 6);

        // Reset asserted while dividing takes effect without a clock edge.
        pix_x = 10'd799;
        pix_y = 10'd479;
        @(negedge clk);
        pix_x = 10'd0;
        pix_y = 10'd480;
        @(negedge clk);
        check("t5_in_div", 32'(state), 32'(ST_DIV));
        #1 rst_n = 1'b0;
        #1;
        check("t5_x", 32'(x_offset), 0);
        check("t5_a", 32'(addr_player), 5);
        check("t5_show", 32'(show_player), 0);
        check("t5_tick", 32'(frame_tick), 0);
        check("t5_busy", 32'(busy), 0);
        check("t5_state", 32'(state), 32'(ST_INIT));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pix_y = 10'd100;
        repeat (3) @(negedge clk);
        do_frame();
        check("t5_first_show", 32'(show_player), 1);
        check("t5_first_x", 32'(x_offset), 0);
        check("t5_first_busy", 32'(g_busy), 0);
        do_frame();
        check("t5_next_x", 32'(x_offset), 8);
        check("t5_next_a", 32'(addr_player), 5);

        // Random speeds against the reference offset/index formula.
        ref_ofs = 8;
        for (int f = 0; f < 20; f++) begin
            speed_sw = 4'($urandom_range(0, 15));
            spd = (speed_sw == 4'd0) ? 1 : int'(speed_sw);
            hold_x = 32'(x_offset);
            hold_a = 32'(addr_player);
            for (int c = 0; c < 6; c++) begin
                pix_x = 10'($urandom_range(0, 799));
                pix_y = 10'($urandom_range(0, 479));
                @(negedge clk);
            end
            check("t6_stable_x", 32'(x_offset), hold_x);
            check("t6_stable_a", 32'(addr_player), hold_a);
            ref_ofs = (ref_ofs + spd) % WRAP;
            do_frame();
            check("t6_x", 32'(x_offset), 32'(ref_ofs));
            check("t6_a", 32'(addr_player), 32'(ref_addr(ref_ofs)));
            check("t6_busy_le17", 32'(g_busy <= 17), 1);
            check("t6_ticks", 32'(g_ticks), 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
